// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two burst-read requesters.
// Each granted burst drives len+1 consecutive ROM reads and returns beats on the shared rdata.
module rom_read_arbiter #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 5,
  parameter int unsigned LW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] adr0,
  input  logic [LW-1:0] len0,
  input  logic          req1,
  input  logic [AW-1:0] adr1,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          rom_en,
  output logic [AW-1:0] rom_adr,
  input  logic [DW-1:0] rom_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [AW-1:0] hold_q, hold_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          ptr_q, ptr_d;
  logic          first_q, first_d;
  logic          rv_q;
  logic          win;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    first_d = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Pointer only matters on a tie; a lone requester always wins.
          win     = (req0 && req1) ? ptr_q : req1;
          owner_d = win;
          adr_d   = win ? adr1 : adr0;
          cnt_d   = win ? len1 : len0;
          first_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        adr_d  = adr_q + AW'(1);
        cnt_d  = cnt_q - LW'(1);
        hold_d = adr_q;
        if (cnt_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        ptr_d   = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      first_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      rv_q    <= (state_q == ISSUE);
    end
  end

  // ROM data returns one cycle after each ISSUE beat, so rv_q marks valid rdata.
  assign rom_en  = (state_q == ISSUE);
  assign rom_adr = rom_en ? adr_q : hold_q;
  assign busy    = (state_q != IDLE);
  assign gnt0    = rom_en && first_q && !owner_q;
  assign gnt1    = rom_en && first_q && owner_q;
  assign rvalid0 = rv_q && !owner_q;
  assign rvalid1 = rv_q && owner_q;
  assign done0   = (state_q == DRAIN) && !owner_q;
  assign done1   = (state_q == DRAIN) && owner_q;
  assign rdata   = rom_data;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural 32x5 synchronous ROM.
module tb_rom_read_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [4:0] adr0, adr1;
  logic [2:0] len0, len1;
  logic       gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy, rom_en;
  logic [4:0] rdata, rom_adr;
  logic [4:0] rom_data = 5'd0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  rom_read_arbiter #(.AW(5), .DW(5), .LW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .adr0(adr0), .len0(len0),
    .req1(req1), .adr1(adr1), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .rom_en(rom_en), .rom_adr(rom_adr), .rom_data(rom_data)
  );

  function automatic logic [4:0] romv(input logic [4:0] a);
    return 5'((a * 7) + 3);
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= romv(rom_adr);

  // {gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy, rom_en}
  wire [7:0] flags = {gnt0, gnt1, rvalid0, rvalid1, done0, done1, busy, rom_en};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [7:0] ef, input logic [4:0] ea,
                     input logic [4:0] er);
    @(negedge clk);
    chk({tag, " flags"}, 32'(flags), 32'(ef));
    if (ef[0]) chk({tag, " adr"}, 32'(rom_adr), 32'(ea));
    if (ef[5] || ef[4]) chk({tag, " rdata"}, 32'(rdata), 32'(romv(er)));
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; adr0 = 5'd0; len0 = 3'd0;
    req1 = 1'b0; adr1 = 5'd0; len1 = 3'd0;

    @(negedge clk);
    chk("rst flags", 32'(flags), 32'h0);
    chk("rst adr", 32'(rom_adr), 32'h0);
    chk("rst rdata", 32'(rdata), 32'h0);
    rst_n = 1'b1;
    cyc("idle", 8'h00, 5'd0, 5'd0);

    // Burst of 3 beats from requester 0
    req0 = 1'b1; adr0 = 5'd11; len0 = 3'd2;
    cyc("t1 g", 8'b1000_0011, 5'd11, 5'd0);
    req0 = 1'b0;
    cyc("t1 b1", 8'b0010_0011, 5'd12, 5'd11);
    cyc("t1 b2", 8'b0010_0011, 5'd13, 5'd12);
    cyc("t1 dn", 8'b0010_1010, 5'd0, 5'd13);
    cyc("t1 id", 8'b0000_0000, 5'd0, 5'd0);

    // Address wrap from 31 to 0
    req1 = 1'b1; adr1 = 5'd30; len1 = 3'd3;
    cyc("t2 g", 8'b0100_0011, 5'd30, 5'd0);
    req1 = 1'b0;
    cyc("t2 b1", 8'b0001_0011, 5'd31, 5'd30);
    cyc("t2 b2", 8'b0001_0011, 5'd0, 5'd31);
    cyc("t2 b3", 8'b0001_0011, 5'd1, 5'd0);
    cyc("t2 dn", 8'b0001_0110, 5'd0, 5'd1);
    cyc("t2 id", 8'b0000_0000, 5'd0, 5'd0);

    // Both requesting continuously: alternate 0,1,0,1 every 3 cycles
    req0 = 1'b1; adr0 = 5'd5; len0 = 3'd0;
    req1 = 1'b1; adr1 = 5'd20; len1 = 3'd0;
    for (int i = 0; i < 2; i++) begin
      cyc("t3 g0", 8'b1000_0011, 5'd5, 5'd0);
      cyc("t3 d0", 8'b0010_1010, 5'd0, 5'd5);
      cyc("t3 i0", 8'b0000_0000, 5'd0, 5'd0);
      cyc("t3 g1", 8'b0100_0011, 5'd20, 5'd0);
      cyc("t3 d1", 8'b0001_0110, 5'd0, 5'd20);
      cyc("t3 i1", 8'b0000_0000, 5'd0, 5'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc("t3 end", 8'b0000_0000, 5'd0, 5'd0);

    // Reset during the 4th ISSUE cycle of an 8-beat burst
    req0 = 1'b1; adr0 = 5'd8; len0 = 3'd7;
    cyc("t4 g", 8'b1000_0011, 5'd8, 5'd0);
    req0 = 1'b0;
    cyc("t4 b1", 8'b0010_0011, 5'd9, 5'd8);
    cyc("t4 b2", 8'b0010_0011, 5'd10, 5'd9);
    cyc("t4 b3", 8'b0010_0011, 5'd11, 5'd10);
    rst_n = 1'b0;
    #1;
    chk("t4 async flags", 32'(flags), 32'h0);
    chk("t4 async adr", 32'(rom_adr), 32'h0);
    cyc("t4 inrst", 8'h00, 5'd0, 5'd0);
    rst_n = 1'b1;
    cyc("t4 post", 8'h00, 5'd0, 5'd0);
    cyc("t4 post2", 8'h00, 5'd0, 5'd0);
    // Tie after reset must go to requester 0
    req0 = 1'b1; adr0 = 5'd2; len0 = 3'd0;
    req1 = 1'b1; adr1 = 5'd9; len1 = 3'd0;
    cyc("t4 ptr", 8'b1000_0011, 5'd2, 5'd0);
    req0 = 1'b0; req1 = 1'b0;
    cyc("t4 pd", 8'b0010_1010, 5'd0, 5'd2);
    cyc("t4 pi", 8'b0000_0000, 5'd0, 5'd0);

    // req1 pulse and adr0 change mid-burst are ignored
    req0 = 1'b1; adr0 = 5'd16; len0 = 3'd3;
    cyc("t5 g", 8'b1000_0011, 5'd16, 5'd0);
    req0 = 1'b0; req1 = 1'b1; adr1 = 5'd25; adr0 = 5'd3;
    cyc("t5 b1", 8'b0010_0011, 5'd17, 5'd16);
    req1 = 1'b0;
    cyc("t5 b2", 8'b0010_0011, 5'd18, 5'd17);
    cyc("t5 b3", 8'b0010_0011, 5'd19, 5'd18);
    cyc("t5 dn", 8'b0010_1010, 5'd0, 5'd19);
    cyc("t5 i1", 8'b0000_0000, 5'd0, 5'd0);
    cyc("t5 i2", 8'b0000_0000, 5'd0, 5'd0);

    // Single-beat burst
    req1 = 1'b1; adr1 = 5'd0; len1 = 3'd0;
    cyc("t6 g", 8'b0100_0011, 5'd0, 5'd0);
    req1 = 1'b0;
    cyc("t6 dn", 8'b0001_0110, 5'd0, 5'd0);
    cyc("t6 id", 8'b0000_0000, 5'd0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
